// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states and the
// branch condition codes the execute-stage comparator resolves.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_cond_e;

  localparam logic [15:0] MISP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state: step toward taken/not-taken, clamp at the ends.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] counter_i,
  input  logic       taken_i,
  output logic [1:0] next_counter_o
);

  always_comb begin
    next_counter_o = counter_i;
    if (taken_i) begin
      if (counter_i != ST) next_counter_o = counter_i + 2'd1;
    end else begin
      if (counter_i != SNT) next_counter_o = counter_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: flop-based table of 2-bit counters, registered
// prediction with write-first bypass, and a saturating mispredict counter.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic        resolve_pred,
  output logic        mispredict,
  output logic [15:0] mispredict_cnt
);

  logic [ENTRIES-1:0][1:0] table_q;
  logic [IDX_W-1:0]        fetch_idx, upd_idx;
  logic [1:0]              upd_ctr, upd_next, fetch_ctr;
  logic                    pred_valid_q, pred_taken_q, pred_taken_d;
  logic                    misp_q, misp_d;
  logic [15:0]             cnt_q, cnt_d;

  // High PC bits alias by design; word-offset bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0],
                            resolve_pc[31:IDX_W+2], resolve_pc[1:0]};

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign upd_idx   = resolve_pc[IDX_W+1:2];
  assign upd_ctr   = table_q[upd_idx];

  bp_sat_counter u_sat (
    .counter_i      (upd_ctr),
    .taken_i        (resolve_taken),
    .next_counter_o (upd_next)
  );

  // Write-first: a same-cycle update to the fetched entry is visible to the prediction.
  always_comb begin
    fetch_ctr = table_q[fetch_idx];
    if (resolve_valid && (upd_idx == fetch_idx)) fetch_ctr = upd_next;
    pred_taken_d = fetch_valid ? fetch_ctr[1] : pred_taken_q;
    misp_d       = resolve_valid && (resolve_taken != resolve_pred);
    cnt_d        = cnt_q;
    if (misp_d && (cnt_q != MISP_CNT_MAX)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= WNT;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      misp_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (resolve_valid) table_q[upd_idx] <= upd_next;
      pred_valid_q <= fetch_valid;
      pred_taken_q <= pred_taken_d;
      misp_q       <= misp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign mispredict     = misp_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, 16, number of pattern-table entries (power of two, 4..256).
REQ-002 Parameter: IDX_W, log2(ENTRIES), index width; index = PC[IDX_W+1:2].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 fetch_valid  input  1  fetch stage requests a prediction this cycle.
REQ-006 fetch_pc  input  32  PC of the fetched instruction.
REQ-007 pred_valid  output  1  registered; prediction available, one cycle after fetch_valid.
REQ-008 pred_taken  output  1  registered; predicted direction for the fetch_pc of the previous cycle.
REQ-009 resolve_valid  input  1  execute stage has resolved a conditional branch this cycle.
REQ-010 resolve_pc  input  32  PC of the resolved branch.
REQ-011 resolve_taken  input  1  actual outcome (the comparator condition_result for branch opcodes).
REQ-012 resolve_pred  input  1  direction that was predicted for this branch (carried down the pipeline).
REQ-013 mispredict  output  1  registered one-cycle pulse; resolved outcome differs from prediction.
REQ-014 mispredict_cnt  output  16  registered saturating count of mispredictions since reset.

Function
REQ-015 Table SHALL hold ENTRIES 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 Prediction SHALL be counter[1] of entry fetch_pc[IDX_W+1:2], presented on pred_taken exactly 1 cycle after fetch_valid; pred_valid SHALL equal fetch_valid delayed 1 cycle.
REQ-017 When fetch_valid=0, pred_valid SHALL be 0 next cycle and pred_taken SHALL hold its previous value.
REQ-018 On resolve_valid=1, entry resolve_pc[IDX_W+1:2] SHALL increment if resolve_taken=1 and decrement if 0, saturating at 11 and 00 (no wrap).
REQ-019 resolve_valid=0 SHALL leave the table unchanged; resolve_pred SHALL have no effect on the table.
REQ-020 Same-cycle fetch and resolve to the same index SHALL be write-first: pred_taken reflects the updated counter.
REQ-021 Same-cycle fetch and resolve to different indices SHALL both complete with no stall.
REQ-022 mispredict SHALL be 1 in the cycle after resolve_valid=1 with resolve_taken != resolve_pred, otherwise 0.
REQ-023 mispredict_cnt SHALL increment by 1 on each mispredict event and hold at 16'hFFFF (no wrap).
REQ-024 Upper PC bits above IDX_W+1 SHALL be ignored (aliasing permitted); PC[1:0] SHALL be ignored.

Reset
REQ-025 While rst_n=0 at a rising edge, all table entries SHALL load 01 (weak-NT), and pred_valid, pred_taken, mispredict and mispredict_cnt SHALL load 0.
REQ-026 fetch_valid and resolve_valid asserted during reset SHALL be ignored; no update or prediction SHALL result from them.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight prediction; the first valid prediction SHALL follow the first fetch_valid sampled with rst_n=1.

Structure
REQ-028 Shared package SHALL define the 2-bit counter encodings (SNT, WNT, WT, ST) and the branch condition codes (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111) used with the comparator.
REQ-029 Saturating-counter next-state logic SHALL live in one sub-module, bp_sat_counter (inputs: counter, taken; output: next counter), instantiated once for the update path.
REQ-030 Table SHALL be flip-flop storage with synchronous reset (no RAM macro) so that full reset is single-cycle.

Verification
REQ-031 Reset then fetch_pc=0x100 -> pred_valid=1, pred_taken=0 next cycle (weak-NT default).
REQ-032 Resolve pc=0x100 taken once, then fetch 0x100 -> pred_taken=1; resolve not-taken once more -> pred_taken=0.
REQ-033 Resolve pc=0x40 taken 5 times then not-taken once -> counter 11 then 10, pred_taken stays 1 (saturation, no wrap).
REQ-034 Same cycle: fetch 0x200 and resolve 0x200 taken (from 01) -> pred_taken=1 next cycle (write-first bypass).
REQ-035 Resolve with resolve_taken=1, resolve_pred=0 -> mispredict=1 for exactly one cycle, mispredict_cnt 0->1; force 65536 mispredicts -> cnt holds 0xFFFF.
REQ-036 Train 0x80 to strong-T, assert rst_n=0 for one edge with fetch_valid=1 -> outputs 0; after release fetch 0x80 -> pred_taken=0.
